// File: rtl/cam_pkg.sv
// Shared types for the camera pixel assembler: FSM states, counter widths
// and the RGB565 pixel layout.
package cam_pkg;

  typedef enum logic {
    SKIP = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int X_BITS = 11;
  localparam int Y_BITS = 10;

  // Field order fixes the RGB565 offsets: r at [4:0], g at [10:5], b at [15:11].
  typedef struct packed {
    logic [4:0] b;
    logic [5:0] g;
    logic [4:0] r;
  } rgb565_t;

  function automatic rgb565_t pack_pixel(input logic [7:0] first,
                                         input logic [7:0] second,
                                         input logic       swap);
    return swap ? rgb565_t'({second, first}) : rgb565_t'({first, second});
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registers a single-bit DVP control signal and reports its rising and falling
// edges, both computed on the registered copy.
module cam_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig,
  output logic o_sig,
  output logic o_rise,
  output logic o_fall
);

  logic sig_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sig_q  <= i_sig;
      prev_q <= sig_q;
    end
  end

  assign o_sig  = sig_q;
  assign o_rise = sig_q & ~prev_q;
  assign o_fall = ~sig_q & prev_q;

endmodule

// File: rtl/cam_pixel_assembler.sv
// DVP byte stream to RGB565 pixel stream with x/y coordinates, start-up frame
// skipping and line/frame length checks. All outputs carry 2 cycles of latency.
module cam_pixel_assembler
  import cam_pkg::*;
#(
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int SKIP_FRAMES = 10,
  parameter bit BYTE_SWAP   = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  output logic              o_vsync,
  output logic              o_href,
  output logic              o_de,
  output logic [15:0]       o_data,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic              o_line_err,
  output logic              o_frame_err
);

  localparam logic [X_BITS:0] H_ACT_L = (X_BITS+1)'(H_ACT);
  localparam logic [Y_BITS:0] V_ACT_L = (Y_BITS+1)'(V_ACT);
  localparam logic [7:0]      SKIP_L  = 8'(SKIP_FRAMES);

  logic vs_s1, vs_rise, vs_fall_unused;
  logic hr_s1, hr_rise, hr_fall;

  cam_edge_det u_vsync_det (
    .clk    (clk),
    .rstn   (rstn),
    .i_sig  (i_vsync),
    .o_sig  (vs_s1),
    .o_rise (vs_rise),
    .o_fall (vs_fall_unused)
  );

  cam_edge_det u_href_det (
    .clk    (clk),
    .rstn   (rstn),
    .i_sig  (i_href),
    .o_sig  (hr_s1),
    .o_rise (hr_rise),
    .o_fall (hr_fall)
  );

  state_e              state_q,     state_d;
  logic [7:0]          skip_cnt_q,  skip_cnt_d;
  logic [7:0]          data_s1_q;
  logic                phase_q,     phase_d;
  logic [7:0]          byte0_q,     byte0_d;
  logic [X_BITS-1:0]   x_q,         x_d;
  logic [X_BITS:0]     pix_cnt_q,   pix_cnt_d;
  logic [Y_BITS-1:0]   y_q,         y_d;
  logic [Y_BITS:0]     line_cnt_q,  line_cnt_d;
  logic                vsync_q,     vsync_d;
  logic                href_q,      href_d;
  logic                de_q,        de_d;
  rgb565_t             data_q,      data_d;
  logic [X_BITS-1:0]   ox_q,        ox_d;
  logic [Y_BITS-1:0]   oy_q,        oy_d;
  logic                line_err_q,  line_err_d;
  logic                frame_err_q, frame_err_d;

  logic            pix_done, run_d, line_bad;
  logic [Y_BITS:0] line_cnt_inc, lines_closed;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (state_q == SKIP && vs_rise) begin
      if (skip_cnt_q == SKIP_L) state_d    = RUN;
      else                      skip_cnt_d = skip_cnt_q + 8'd1;
    end
    run_d = (state_d == RUN);

    pix_done = hr_s1 & phase_q;
    phase_d  = hr_s1 & ~phase_q;
    byte0_d  = (hr_s1 & ~phase_q) ? data_s1_q : byte0_q;

    x_d       = x_q;
    pix_cnt_d = pix_cnt_q;
    if (hr_rise) begin
      x_d       = '0;
      pix_cnt_d = '0;
    end else if (pix_done) begin
      x_d       = (x_q == '1) ? x_q : x_q + 1'b1;
      pix_cnt_d = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 1'b1;
    end

    // A line closing in the same cycle as a vsync rise still counts toward the old frame.
    line_cnt_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 1'b1;
    lines_closed = hr_fall ? line_cnt_inc : line_cnt_q;
    y_d          = y_q;
    line_cnt_d   = line_cnt_q;
    if (vs_rise) begin
      y_d        = '0;
      line_cnt_d = '0;
    end else if (hr_fall) begin
      y_d        = (y_q == '1) ? y_q : y_q + 1'b1;
      line_cnt_d = line_cnt_inc;
    end

    line_bad   = phase_q | (pix_cnt_q != H_ACT_L);
    line_err_d = vs_rise ? 1'b0 : line_err_q;
    if (state_q == RUN && hr_fall && line_bad) line_err_d = 1'b1;
    frame_err_d = (state_q == RUN) & vs_rise & (lines_closed != V_ACT_L);

    vsync_d = vs_s1 & run_d;
    href_d  = hr_s1 & run_d;
    de_d    = pix_done & run_d;
    data_d  = de_d ? pack_pixel(byte0_q, data_s1_q, BYTE_SWAP) : data_q;
    ox_d    = de_d ? x_q : ox_q;
    oy_d    = de_d ? y_q : oy_q;
  end

  // NOTE: the pixel data path is reset too, so outputs read 0 while rstn is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SKIP;
      skip_cnt_q  <= '0;
      data_s1_q   <= '0;
      phase_q     <= 1'b0;
      byte0_q     <= '0;
      x_q         <= '0;
      pix_cnt_q   <= '0;
      y_q         <= '0;
      line_cnt_q  <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      de_q        <= 1'b0;
      data_q      <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      data_s1_q   <= i_data;
      phase_q     <= phase_d;
      byte0_q     <= byte0_d;
      x_q         <= x_d;
      pix_cnt_q   <= pix_cnt_d;
      y_q         <= y_d;
      line_cnt_q  <= line_cnt_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      de_q        <= de_d;
      data_q      <= data_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_vsync     = vsync_q;
  assign o_href      = href_q;
  assign o_de        = de_q;
  assign o_data      = data_q;
  assign o_x         = ox_q;
  assign o_y         = oy_q;
  assign o_line_err  = line_err_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Directed bench: a small-geometry instance (8x4, skip 2) and a wide-line,
// byte-swapped instance (H_ACT=2048, skip 0) share one DVP stimulus stream.
module tb_cam_pixel_assembler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_href = 1'b0;
  logic [7:0]  i_data = 8'h00;

  logic        o_vsync, o_href, o_de, o_line_err, o_frame_err;
  logic [15:0] o_data;
  logic [10:0] o_x;
  logic [9:0]  o_y;

  logic        w_vsync, w_href, w_de, w_line_err, w_frame_err;
  logic [15:0] w_data;
  logic [10:0] w_x;
  logic [9:0]  w_y;

  cam_pixel_assembler #(.H_ACT(8), .V_ACT(4), .SKIP_FRAMES(2), .BYTE_SWAP(1'b0)) dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
    .o_vsync(o_vsync), .o_href(o_href), .o_de(o_de), .o_data(o_data),
    .o_x(o_x), .o_y(o_y), .o_line_err(o_line_err), .o_frame_err(o_frame_err)
  );

  cam_pixel_assembler #(.H_ACT(2048), .V_ACT(2), .SKIP_FRAMES(0), .BYTE_SWAP(1'b1)) dut_w (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
    .o_vsync(w_vsync), .o_href(w_href), .o_de(w_de), .o_data(w_data),
    .o_x(w_x), .o_y(w_y), .o_line_err(w_line_err), .o_frame_err(w_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp;
    logic [15:0] exp_sw;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [10:0] x;
    logic [9:0]  y;
    int          cyc;
  } pix_rec_t;

  int       cyc = 0;
  int       de_cnt = 0, href_cnt = 0, vs_cnt = 0, fe_cnt = 0;
  int       w_de_cnt = 0;
  logic [10:0] w_last_x = '0;
  pix_rec_t pix_log[8192];
  pix_rec_t w_log[8192];

  int       n_cmp = 0, n_bad = 0;
  vec_t     vecs[8];
  logic [7:0] line_bytes[4200];
  int       sent_cyc[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_de) begin
      pix_log[de_cnt % 8192] = '{o_data, o_x, o_y, cyc};
      de_cnt++;
    end
    if (o_href) href_cnt++;
    if (o_vsync) vs_cnt++;
    if (o_frame_err) fe_cnt++;
    if (w_de) begin
      w_log[w_de_cnt % 8192] = '{w_data, w_x, w_y, cyc};
      w_de_cnt++;
      w_last_x = w_x;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    repeat (3) tick();
    i_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_line(input int n);
    i_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_data = line_bytes[i];
      if (i % 2 == 1 && i < 16) sent_cyc[i/2] = cyc;
      tick();
    end
    i_href = 1'b0;
    i_data = 8'h00;
    repeat (4) tick();
  endtask

  task automatic fill_pattern(input int n);
    for (int i = 0; i < n; i++) line_bytes[i] = 8'(i * 7 + 3);
  endtask

  task automatic send_frame(input int lines, input int nbytes);
    vsync_pulse();
    fill_pattern(nbytes);
    for (int l = 0; l < lines; l++) send_line(nbytes);
  endtask

  function automatic logic [41:0] all_outs();
    return {o_vsync, o_href, o_de, o_data, o_x, o_y, o_line_err, o_frame_err};
  endfunction

  initial begin
    int b_de, b_href, b_vs, b_fe, b_w, b_f3;
    int ymax;

    vecs[0] = '{8'hAB, 8'hCD, 16'hABCD, 16'hCDAB};
    vecs[1] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{8'h12, 8'h34, 16'h1234, 16'h3412};
    vecs[4] = '{8'hF8, 8'h00, 16'hF800, 16'h00F8};
    vecs[5] = '{8'h07, 8'hE0, 16'h07E0, 16'hE007};
    vecs[6] = '{8'h00, 8'h1F, 16'h001F, 16'h1F00};
    vecs[7] = '{8'h5A, 8'hA5, 16'h5AA5, 16'hA55A};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", 64'(all_outs()), 64'd0);
    check("reset_outputs_w", 64'({w_vsync, w_href, w_de, w_data, w_x, w_y, w_line_err, w_frame_err}), 64'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Two skipped frames, then one passed frame
    b_de = de_cnt; b_href = href_cnt; b_vs = vs_cnt; b_fe = fe_cnt;
    send_frame(4, 16);
    send_frame(4, 16);
    check("skip_de", 64'(de_cnt - b_de), 64'd0);
    check("skip_href", 64'(href_cnt - b_href), 64'd0);
    check("skip_vsync", 64'(vs_cnt - b_vs), 64'd0);
    b_de = de_cnt; b_href = href_cnt; b_vs = vs_cnt;
    send_frame(4, 16);
    check("run_frame_de", 64'(de_cnt - b_de), 64'd32);
    check("run_frame_href", 64'(href_cnt - b_href), 64'd64);
    check("run_frame_vsync", 64'(vs_cnt - b_vs), 64'd3);

    // Frame 3: table line, odd line, good line
    vsync_pulse();
    check("no_frame_err_good", 64'(fe_cnt - b_fe), 64'd0);
    check("line_err_clear_start", 64'(o_line_err), 64'd0);
    b_f3 = de_cnt;
    b_w  = w_de_cnt;
    for (int i = 0; i < 8; i++) begin
      line_bytes[2*i]   = vecs[i].b0;
      line_bytes[2*i+1] = vecs[i].b1;
    end
    send_line(16);
    for (int i = 0; i < 8; i++) begin
      pix_rec_t r, rw;
      r  = pix_log[(b_f3 + i) % 8192];
      rw = w_log[(b_w + i) % 8192];
      check($sformatf("vec%0d_data", i), 64'(r.d), 64'(vecs[i].exp));
      check($sformatf("vec%0d_x", i), 64'(r.x), 64'(i));
      check($sformatf("vec%0d_y", i), 64'(r.y), 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(r.cyc - sent_cyc[i]), 64'd2);
      check($sformatf("vec%0d_swap_data", i), 64'(rw.d), 64'(vecs[i].exp_sw));
    end
    check("table_line_de", 64'(de_cnt - b_f3), 64'd8);
    check("line_err_good_line", 64'(o_line_err), 64'd0);

    b_de = de_cnt;
    fill_pattern(16);
    send_line(15);
    check("odd_line_de", 64'(de_cnt - b_de), 64'd7);
    check("line_err_odd", 64'(o_line_err), 64'd1);
    send_line(16);
    check("line_err_sticky", 64'(o_line_err), 64'd1);
    ymax = 0;
    for (int i = b_f3; i < de_cnt; i++)
      if (int'(pix_log[i % 8192].y) > ymax) ymax = int'(pix_log[i % 8192].y);
    check("short_frame_ymax", 64'(ymax), 64'd2);

    b_fe = fe_cnt;
    vsync_pulse();
    check("short_frame_err_pulse", 64'(fe_cnt - b_fe), 64'd1);
    check("line_err_cleared", 64'(o_line_err), 64'd0);

    // Frame 4: clean frame, no errors
    b_fe = fe_cnt;
    fill_pattern(16);
    for (int l = 0; l < 4; l++) send_line(16);
    check("clean_line_err", 64'(o_line_err), 64'd0);
    vsync_pulse();
    check("clean_frame_err", 64'(fe_cnt - b_fe), 64'd0);

    // Overlong line on the wide instance: x saturates
    check("w_line_err_cleared", 64'(w_line_err), 64'd0);
    b_w = w_de_cnt;
    fill_pattern(4200);
    send_line(4200);
    check("w_long_de", 64'(w_de_cnt - b_w), 64'd2100);
    check("w_x_saturated", 64'(w_last_x), 64'd2047);
    check("w_long_line_err", 64'(w_line_err), 64'd1);

    // Reset mid-line while running
    vsync_pulse();
    fill_pattern(16);
    i_href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_data = line_bytes[i];
      tick();
    end
    check("pre_reset_href", 64'(o_href), 64'd1);
    rstn = 1'b0;
    #1;
    check("async_reset_outputs", 64'(all_outs()), 64'd0);
    i_href = 1'b0;
    i_data = 8'h00;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    b_de = de_cnt; b_href = href_cnt;
    send_frame(4, 16);
    send_frame(4, 16);
    check("reskip_de", 64'(de_cnt - b_de), 64'd0);
    check("reskip_href", 64'(href_cnt - b_href), 64'd0);
    b_de = de_cnt;
    send_frame(4, 16);
    check("rerun_de", 64'(de_cnt - b_de), 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
